// File: rtl/comp_encoder.sv
// Comparator-waveform encoder: turns accepted samples into a pulse of `value` ticks per rising half-frame.
// Optional macro COMP_ENCODER_CLAMP_EN: out-of-range samples are clamped to MAXCOUNT-1 instead of dropped.
module comp_encoder #(
  parameter int unsigned WIDTH    = 7,
  parameter int unsigned MAXCOUNT = 100
) (
  input  logic             clkCount,
  input  logic             reset,
  input  logic [WIDTH-1:0] value,
  input  logic             valueValid,
  output logic             valueReady,
  output logic             comp,
  output logic             frameUp,
  output logic             frameStart
);

  localparam int unsigned TW = (MAXCOUNT > 1) ? $clog2(MAXCOUNT) : 1;
  localparam int unsigned CW = (TW > WIDTH) ? TW : WIDTH;
  localparam logic [TW-1:0]    TICK_LAST = TW'(MAXCOUNT - 1);
  localparam logic [WIDTH-1:0] VALUE_MAX = WIDTH'(MAXCOUNT - 1);

  typedef enum logic [1:0] {IDLE, UP, DOWN} state_e;

  state_e           state_q, state_d;
  logic [TW-1:0]    tick_q, tick_d;
  logic [WIDTH-1:0] active_q, active_d;
  logic [WIDTH-1:0] pending_q, pending_d;
  logic             pending_full_q, pending_full_d;
  logic             comp_q, comp_d;
  logic             frame_up_q, frame_up_d;
  logic             frame_start_q, frame_start_d;
  logic             xfer;
  logic             boundary;
  logic             in_range;

  assign valueReady = !pending_full_q && reset;
  assign xfer       = valueValid && valueReady;
  assign in_range   = 32'(value) < MAXCOUNT;

  // Next-state, sample buffering and registered-output computation.
  always_comb begin
    state_d        = state_q;
    tick_d         = tick_q;
    active_d       = active_q;
    pending_d      = pending_q;
    pending_full_d = pending_full_q;

    case (state_q)
      IDLE: begin
        state_d = UP;
        tick_d  = '0;
      end
      UP: begin
        if (tick_q == TICK_LAST) begin
          state_d = DOWN;
          tick_d  = '0;
        end else begin
          tick_d = tick_q + TW'(1);
        end
      end
      DOWN: begin
        if (tick_q == TICK_LAST) begin
          state_d = UP;
          tick_d  = '0;
        end else begin
          tick_d = tick_q + TW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        tick_d  = '0;
      end
    endcase

    boundary = (state_d == UP) && (state_q != UP);

    // Promotion reads the pre-edge pending, so a same-edge transfer lands in pending.
    if (boundary && pending_full_q) begin
      active_d       = pending_q;
      pending_full_d = 1'b0;
    end

    if (xfer) begin
`ifdef COMP_ENCODER_CLAMP_EN
      pending_d      = in_range ? value : VALUE_MAX;
      pending_full_d = 1'b1;
`else
      if (in_range) begin
        pending_d      = value;
        pending_full_d = 1'b1;
      end
`endif
    end

    frame_up_d    = (state_d == UP);
    frame_start_d = (state_d == UP) && (tick_d == '0);
    comp_d        = (state_d == UP) && (CW'(tick_d) < CW'(active_d));
  end

  always_ff @(posedge clkCount or negedge reset) begin
    if (!reset) begin
      state_q        <= IDLE;
      tick_q         <= '0;
      active_q       <= '0;
      pending_q      <= '0;
      pending_full_q <= 1'b0;
      comp_q         <= 1'b0;
      frame_up_q     <= 1'b0;
      frame_start_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      tick_q         <= tick_d;
      active_q       <= active_d;
      pending_q      <= pending_d;
      pending_full_q <= pending_full_d;
      comp_q         <= comp_d;
      frame_up_q     <= frame_up_d;
      frame_start_q  <= frame_start_d;
    end
  end

  assign comp       = comp_q;
  assign frameUp    = frame_up_q;
  assign frameStart = frame_start_q;

endmodule

// File: tb/tb_comp_encoder.sv
// Bench for comp_encoder: frame-position reference model, per-cycle compare, directed and random stimulus.
module tb_comp_encoder;

  localparam int MAXC = 100;
  localparam int W    = 7;

  logic         clkCount = 1'b0;
  logic         reset    = 1'b1;
  logic [W-1:0] value    = '0;
  logic         valueValid = 1'b0;
  logic         valueReady;
  logic         comp;
  logic         frameUp;
  logic         frameStart;

  int total = 0;
  int bad   = 0;

  comp_encoder #(.WIDTH(W), .MAXCOUNT(MAXC)) dut (
    .clkCount  (clkCount),
    .reset     (reset),
    .value     (value),
    .valueValid(valueValid),
    .valueReady(valueReady),
    .comp      (comp),
    .frameUp   (frameUp),
    .frameStart(frameStart)
  );

  always #5 clkCount = ~clkCount;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: position within the frame counted from reset release.
  bit started = 0;
  int pos     = 0;
  bit m_full  = 0;
  int m_pend  = 0;
  int m_act   = 0;

  always @(posedge clkCount or negedge reset) begin : model
    bit rdy;
    if (!reset) begin
      started = 0; pos = 0; m_full = 0; m_pend = 0; m_act = 0;
    end else begin
      rdy = !m_full;
      if (!started) begin
        started = 1;
        pos = 0;
      end else begin
        pos = (pos + 1) % (2 * MAXC);
      end
      if (pos == 0 && m_full) begin
        m_act  = m_pend;
        m_full = 0;
      end
      if (valueValid && rdy) begin
        if (int'(value) < MAXC) begin
          m_pend = int'(value);
          m_full = 1;
        end else begin
`ifdef COMP_ENCODER_CLAMP_EN
          m_pend = MAXC - 1;
          m_full = 1;
`endif
        end
      end
    end
  end

  // Per-cycle compare against the model, away from the active edge.
  always @(negedge clkCount) begin
    int e_up, e_start, e_comp, e_rdy;
    e_up    = (started && pos < MAXC) ? 1 : 0;
    e_start = (started && pos == 0) ? 1 : 0;
    e_comp  = (e_up == 1 && pos < m_act) ? 1 : 0;
    e_rdy   = (reset && !m_full) ? 1 : 0;
    chk("frameUp", int'(frameUp), e_up);
    chk("frameStart", int'(frameStart), e_start);
    chk("comp", int'(comp), e_comp);
    chk("valueReady", int'(valueReady), e_rdy);
  end

  // Advance one edge; returns just after it, reporting whether a transfer happened on it.
  task automatic tick_once(output logic took);
    logic rdy;
    @(negedge clkCount);
    #1 rdy = valueReady;
    @(posedge clkCount);
    took = valueValid && rdy && reset;
    #2;
  endtask

  task automatic run(input int n);
    logic t;
    for (int i = 0; i < n; i++) tick_once(t);
  endtask

  task automatic send(input logic [W-1:0] v);
    logic took;
    int guard;
    valueValid = 1'b1;
    value = v;
    guard = 0;
    do begin
      tick_once(took);
      guard++;
    end while (!took && guard < 500);
    valueValid = 1'b0;
    if (!took) chk("send_timeout", 0, 1);
  endtask

  task automatic wait_frame();
    int guard;
    logic t;
    guard = 0;
    do begin
      tick_once(t);
      guard++;
    end while (!frameStart && guard < 300);
    if (!frameStart) chk("frame_timeout", 0, 1);
  endtask

  // Counts comp-high edges over one full frame starting at the current frameStart.
  task automatic count_comp(output int hi);
    logic t;
    hi = int'(comp);
    for (int i = 0; i < 2 * MAXC - 1; i++) begin
      tick_once(t);
      hi += int'(comp);
    end
  endtask

  initial begin
    int hi, starts, ups;
    #1 reset = 1'b0;
    #1 chk("reset_comp", int'(comp), 0);
    chk("reset_ready", int'(valueReady), 0);
    run(3);
    reset = 1'b1;
    run(1);
    chk("first_frameUp", int'(frameUp), 1);
    chk("first_frameStart", int'(frameStart), 1);

    starts = 0; ups = 0;
    for (int i = 0; i < 2 * 2 * MAXC; i++) begin
      run(1);
      starts += int'(frameStart);
      ups += int'(frameUp);
    end
    chk("frameStart_count_400", starts, 2);
    chk("frameUp_count_400", ups, 200);

    send(7'd37);
    wait_frame();
    count_comp(hi);
    chk("high_ticks_37", hi, 37);

    wait_frame();
    run(49);
    send(7'd80);
    wait_frame();
    count_comp(hi);
    chk("high_ticks_80", hi, 80);

    send(7'd10);
    send(7'd20);
    send(7'd30);
    send(7'd120);
    wait_frame();
    count_comp(hi);
`ifdef COMP_ENCODER_CLAMP_EN
    chk("high_ticks_120", hi, 99);
`else
    chk("high_ticks_120", hi, 30);
`endif

    send(7'd0);
    wait_frame();
    count_comp(hi);
    chk("high_ticks_0", hi, 0);

    send(7'd60);
    wait_frame();
    wait_frame();
    run(40);
    chk("pre_reset_comp", int'(comp), 1);
    reset = 1'b0;
    #1 chk("async_comp", int'(comp), 0);
    chk("async_frameUp", int'(frameUp), 0);
    chk("async_ready", int'(valueReady), 0);
    run(2);
    reset = 1'b1;
    run(1);
    chk("restart_frameStart", int'(frameStart), 1);
    count_comp(hi);
    chk("high_ticks_after_reset", hi, 0);

    for (int i = 0; i < 6000; i++) begin
      valueValid = ($urandom_range(0, 3) == 0);
      value = W'($urandom_range(0, 127));
      if ($urandom_range(0, 999) == 0) begin
        reset = 1'b0;
        run($urandom_range(1, 3));
        reset = 1'b1;
      end
      run(1);
    end
    valueValid = 1'b0;
    run(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
